dsm_loop_register: RTL and testbench

First-order delta-sigma loop state stage that wraps the DSM core's 5-bit `spec_adder` (`Out = Data1 + Data2 - Data3`).
- **Upstream side:** accepts input samples over a valid/ready handshake into a one-entry buffer, and holds each sample for a programmable oversampling ratio (OSR).
- **Adder side:** drives the adder's three operands (current sample, integrator state, quantizer feedback) and registers the adder result back as the integrator state on every run cycle.
- **Downstream side:** emits a 1-bit stream whose density equals sample/16.

---
 rtl/dsm_loop_register.sv | 188 ++++++++++++++++++
 tb/tb_dsm_loop_register.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_loop_register.sv
// -----------------------------------------------------------------------------
// dsm_loop_register
//   Loop-state stage of a first-order delta-sigma modulator built around an
//   external WIDTH-bit adder computing Out = Data1 + Data2 - Data3.
//   Upstream samples enter a one-entry buffer over valid/ready, each sample is
//   held for max(osr,1) loop ticks, and the integrator state is re-registered
//   from the adder result once per run cycle. The MSB of the state is the
//   quantizer decision, so the bit stream density equals Cur_Data/16.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                run enable (level); dropping it clears all loop state
//   osr               ticks per sample, 0 behaves as 1, sampled at frame start
//   In_Data/in_valid/in_ready   upstream sample handshake
//   Cur_Data          held sample        -> adder Data1
//   Acc_Data          integrator state   -> adder Data2
//   Fb_Data           quantizer feedback -> adder Data3
//   Sum_Data          adder Out_Data
//   bit_out/bit_valid quantized bit stream
//   sat, underrun     sticky flags, cleared by clr_flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module dsm_loop_register #(
  parameter int WIDTH = 5,
  parameter int OSR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OSR_W-1:0] osr,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Cur_Data,
  output logic [WIDTH-1:0] Acc_Data,
  output logic [WIDTH-1:0] Fb_Data,
  input  logic [WIDTH-1:0] Sum_Data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             sat,
  output logic             underrun,
  input  logic             clr_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Largest legal sample: half of full scale minus one, keeps the adder from wrapping.
  localparam logic [WIDTH-1:0] SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [OSR_W-1:0] CNT_ONE    = {{(OSR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q,   buf_d;
  logic             full_q,  full_d;
  logic [WIDTH-1:0] cur_q,   cur_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [OSR_W-1:0] cnt_q,   cnt_d;
  logic             bit_q,   bit_d;
  logic             bval_q,  bval_d;
  logic             sat_q,   sat_d;
  logic             und_q,   und_d;

  logic             accept_s;
  logic             over_s;
  logic [WIDTH-1:0] clamped_s;
  logic [OSR_W-1:0] cnt_load_s;

  assign in_ready   = (state_q != S_IDLE) && !full_q;
  assign accept_s   = in_valid && in_ready;
  // Any sample with the MSB set is above the legal range.
  assign over_s     = In_Data[WIDTH-1];
  assign clamped_s  = over_s ? SAMPLE_MAX : In_Data;
  assign cnt_load_s = (osr == {OSR_W{1'b0}}) ? {OSR_W{1'b0}} : (osr - CNT_ONE);

  assign Cur_Data  = cur_q;
  assign Acc_Data  = acc_q;
  assign Fb_Data   = {acc_q[WIDTH-1], {(WIDTH-1){1'b0}}};
  assign bit_out   = bit_q;
  assign bit_valid = bval_q;
  assign sat       = sat_q;
  assign underrun  = und_q;

  // Next-state logic for the FSM, buffer, loop state and sticky flags.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    full_d  = full_q;
    cur_d   = cur_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bval_d  = bval_q;
    // Clear first so that a set later in this block takes priority.
    if (clr_flags) begin
      sat_d = 1'b0;
      und_d = 1'b0;
    end else begin
      sat_d = sat_q;
      und_d = und_q;
    end

    if (!en) begin
      state_d = S_IDLE;
      buf_d   = {WIDTH{1'b0}};
      full_d  = 1'b0;
      cur_d   = {WIDTH{1'b0}};
      acc_d   = {WIDTH{1'b0}};
      cnt_d   = {OSR_W{1'b0}};
      bit_d   = 1'b0;
      bval_d  = 1'b0;
    end else begin
      // in_ready implies the buffer is empty, so a load below never collides with this.
      if (accept_s) begin
        buf_d  = clamped_s;
        full_d = 1'b1;
        sat_d  = sat_d | over_s;
      end else begin
        buf_d  = buf_q;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (full_q) begin
            state_d = S_RUN;
            cur_d   = buf_q;
            full_d  = 1'b0;
            cnt_d   = cnt_load_s;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_RUN: begin
          acc_d  = Sum_Data;
          bit_d  = acc_q[WIDTH-1];
          bval_d = 1'b1;
          if (cnt_q != {OSR_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = cnt_load_s;
            if (full_q) begin
              cur_d  = buf_q;
              full_d = 1'b0;
            end else begin
              // Frame end with nothing buffered: keep the old sample.
              und_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= {WIDTH{1'b0}};
      full_q  <= 1'b0;
      cur_q   <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      cnt_q   <= {OSR_W{1'b0}};
      bit_q   <= 1'b0;
      bval_q  <= 1'b0;
      sat_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      bval_q  <= bval_d;
      sat_q   <= sat_d;
      und_q   <= und_d;
    end
  end

endmodule

// File: tb/tb_dsm_loop_register.sv
// -----------------------------------------------------------------------------
// tb_dsm_loop_register
//   Directed bench for dsm_loop_register. The adder is modelled here as a
//   plain combinational Cur + Acc - Fb. For constant-fed phases the expected
//   (bit, state) sequence is generated from the loop equations and queued,
//   then popped whenever the DUT presents a valid bit.
// -----------------------------------------------------------------------------
module tb_dsm_loop_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] osr;
  logic [4:0] In_Data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] Cur_Data;
  logic [4:0] Acc_Data;
  logic [4:0] Fb_Data;
  logic [4:0] Sum_Data;
  logic       bit_out;
  logic       bit_valid;
  logic       sat;
  logic       underrun;
  logic       clr_flags;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected {bit_out, Acc_Data} per loop tick.
  logic [5:0] exp_q[$];

  dsm_loop_register #(.WIDTH(5), .OSR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .osr       (osr),
    .In_Data   (In_Data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Cur_Data  (Cur_Data),
    .Acc_Data  (Acc_Data),
    .Fb_Data   (Fb_Data),
    .Sum_Data  (Sum_Data),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .sat       (sat),
    .underrun  (underrun),
    .clr_flags (clr_flags)
  );

  assign Sum_Data = Cur_Data + Acc_Data - Fb_Data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run the loop from a cleared state with a constant input and check nbits ticks.
  task automatic run_const(input logic [4:0] x, input logic [7:0] o, input int nbits);
    int         a;
    int         first_c;
    logic       b;
    logic [4:0] xe;
    logic [5:0] e;
    xe = (x > 5'd15) ? 5'd15 : x;
    a  = 0;
    for (int i = 0; i < nbits; i++) begin
      b = (a >= 16);
      a = a + int'(xe) - (b ? 16 : 0);
      exp_q.push_back({b, 5'(a)});
    end
    In_Data  = x;
    in_valid = 1'b1;
    osr      = o;
    en       = 1'b1;
    tick();
    chk("ready_after_en", 32'(in_ready), 32'd1);
    first_c = -1;
    for (int c = 0; c < nbits + 12 && exp_q.size() > 0; c++) begin
      tick();
      if (bit_valid) begin
        if (first_c < 0) first_c = c;
        e = exp_q.pop_front();
        chk("bit_out",  32'(bit_out),  32'(e[5]));
        chk("acc_data", 32'(Acc_Data), 32'(e[4:0]));
        chk("fb_data",  32'(Fb_Data),  e[4] ? 32'd16 : 32'd0);
        chk("cur_data", 32'(Cur_Data), 32'(xe));
      end
    end
    chk("first_bit_latency", 32'(first_c), 32'd2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Drop en and check that loop state clears while flags are retained.
  task automatic drop_en(input logic exp_sat, input logic exp_und);
    en = 1'b0;
    tick();
    chk("dis_acc",      32'(Acc_Data),  32'd0);
    chk("dis_cur",      32'(Cur_Data),  32'd0);
    chk("dis_bit_vld",  32'(bit_valid), 32'd0);
    chk("dis_bit_out",  32'(bit_out),   32'd0);
    chk("dis_in_ready", 32'(in_ready),  32'd0);
    chk("dis_sat",      32'(sat),       32'(exp_sat));
    chk("dis_underrun", 32'(underrun),  32'(exp_und));
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    osr       = 8'd0;
    In_Data   = 5'd0;
    in_valid  = 1'b0;
    clr_flags = 1'b0;

    // Reset values.
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_cur",       32'(Cur_Data),  32'd0);
    chk("rst_acc",       32'(Acc_Data),  32'd0);
    chk("rst_fb",        32'(Fb_Data),   32'd0);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_sat",       32'(sat),       32'd0);
    chk("rst_underrun",  32'(underrun),  32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Half density, extremes and a mid-range value.
    run_const(5'd8, 8'd4, 24);
    drop_en(1'b0, 1'b0);
    run_const(5'd15, 8'd3, 32);
    drop_en(1'b0, 1'b0);
    run_const(5'd0, 8'd2, 16);
    drop_en(1'b0, 1'b0);
    run_const(5'd3, 8'd6, 20);
    drop_en(1'b0, 1'b0);

    // Clamp: 20 is held as 15 and sets sat.
    run_const(5'd20, 8'd5, 20);
    chk("clamp_sat", 32'(sat), 32'd1);
    drop_en(1'b1, 1'b0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_cleared", 32'(sat), 32'd0);

    // Clear in the same cycle as a new clamp: the set wins.
    In_Data  = 5'd20;
    in_valid = 1'b1;
    osr      = 8'd5;
    en       = 1'b1;
    tick();
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_set_wins", 32'(sat), 32'd1);
    drop_en(1'b1, 1'b0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_cleared2", 32'(sat), 32'd0);

    // Underrun with osr = 2: one sample, then valid drops.
    In_Data  = 5'd6;
    in_valid = 1'b1;
    osr      = 8'd2;
    en       = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    chk("ur_cur_loaded", 32'(Cur_Data), 32'd6);
    chk("ur_none_yet",   32'(underrun), 32'd0);
    tick();
    chk("ur_none_mid",   32'(underrun), 32'd0);
    tick();
    chk("ur_set",        32'(underrun), 32'd1);
    chk("ur_cur_reused", 32'(Cur_Data), 32'd6);
    chk("ur_in_ready",   32'(in_ready), 32'd1);
    clr_flags = 1'b1;
    tick();
    chk("ur_cleared", 32'(underrun), 32'd0);
    // Accept at frame end with empty buffer, with clr still high.
    In_Data  = 5'd9;
    in_valid = 1'b1;
    tick();
    chk("ur_set_wins",    32'(underrun), 32'd1);
    chk("ur_fe_cur_held", 32'(Cur_Data), 32'd6);
    chk("ur_fe_buffered", 32'(in_ready), 32'd0);
    clr_flags = 1'b0;
    in_valid  = 1'b0;
    tick();
    tick();
    chk("ur_next_sample", 32'(Cur_Data), 32'd9);
    chk("ur_retained",    32'(underrun), 32'd1);
    drop_en(1'b0, 1'b1);

    // osr = 0 behaves as a one-tick frame.
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("osr0_pre_clear", 32'(underrun), 32'd0);
    In_Data  = 5'd4;
    in_valid = 1'b1;
    osr      = 8'd0;
    en       = 1'b1;
    tick();
    chk("reen_in_ready", 32'(in_ready), 32'd1);
    chk("reen_cur",      32'(Cur_Data), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("osr0_cur",   32'(Cur_Data), 32'd4);
    chk("osr0_no_ur", 32'(underrun), 32'd0);
    tick();
    chk("osr0_ur",    32'(underrun), 32'd1);
    chk("osr0_acc",   32'(Acc_Data), 32'd4);

    // Asynchronous reset mid-run.
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cur",       32'(Cur_Data),  32'd0);
    chk("arst_acc",       32'(Acc_Data),  32'd0);
    chk("arst_bit_valid", 32'(bit_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd0);
    chk("arst_underrun",  32'(underrun),  32'd0);
    en = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(in_ready), 32'd0);
    en = 1'b1;
    tick();
    chk("post_rst_wait", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
